// File: rtl/cardinal_ring_hop_pkg.sv
// +----------------------------------------------------------------------+
// | cardinal_pkg : packet field positions and shared types for Cardinal  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package cardinal_pkg;

  // Bit 0 is the MSB of a packet; fields are given in [0:N-1] numbering.
  localparam int VC_BIT      = 0;
  localparam int DIR_BIT     = 1;
  localparam int HOP_MSB     = 8;
  localparam int HOP_LSB     = 15;
  localparam int SRC_MSB     = 16;
  localparam int PAYLOAD_MSB = 32;
  localparam int PACKET_SIZE = 64;

  typedef enum logic {
    SRC_IN  = 1'b0,
    SRC_INJ = 1'b1
  } src_sel_e;

endpackage

`default_nettype wire

// File: rtl/cardinal_vc_buf.sv
// +----------------------------------------------------------------------+
// | cardinal_vc_buf : two-VC, single-entry-per-VC packet buffer          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module cardinal_vc_buf #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_vc,
  input  logic [0:WIDTH-1]      i_data,
  input  logic [1:0]            i_clr,
  output logic [1:0]            o_full,
  output logic [1:0][0:WIDTH-1] o_data
);

  logic [1:0]            r_full;
  logic [1:0][0:WIDTH-1] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= '0;
      r_data <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (i_we && (i_vc == 1'(v))) begin
          r_full[v] <= 1'b1;
          r_data[v] <= i_data;
        end else if (i_clr[v]) begin
          r_full[v] <= 1'b0;
        end
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/cardinal_ring_hop.sv
// +----------------------------------------------------------------------+
// | cardinal_ring_hop : one directional ring channel with NIC inject/eject|
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cardinal_ring_hop #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   polarity,
  input  logic                   cwsi,
  output logic                   cwri,
  input  logic [0:PACKET_SIZE-1] cwdi,
  output logic                   cwso,
  input  logic                   cwro,
  output logic [0:PACKET_SIZE-1] cwdo,
  input  logic                   pesi,
  output logic                   peri,
  input  logic [0:PACKET_SIZE-1] pedi,
  output logic                   peso,
  input  logic                   pero,
  output logic [0:PACKET_SIZE-1] pedo
);

  import cardinal_pkg::*;

  logic [1:0]                  w_in_full, w_inj_full, w_out_full, w_ej_full;
  logic [1:0][0:PACKET_SIZE-1] w_in_data, w_inj_data, w_out_data, w_ej_data;
  logic [1:0]                  w_in_clr, w_inj_clr, w_out_clr, w_ej_clr;

  logic                   w_rv;
  logic [0:PACKET_SIZE-1] w_in_pkt, w_inj_pkt, w_in_shift, w_inj_shift;
  logic                   w_in_fwd, w_inj_fwd, w_in_ok, w_inj_ok, w_conflict;
  logic                   w_in_go, w_inj_go, w_toggle;
  logic                   w_in_we, w_inj_we, w_out_we, w_ej_we;
  logic [0:PACKET_SIZE-1] w_out_wdata, w_ej_wdata;
  src_sel_e               r_prio [2];

  // External traffic uses VC==polarity; the other VC is routed internally.
  assign w_rv = ~polarity;

  assign cwri    = reset & ~w_in_full[polarity];
  assign peri    = reset & ~w_inj_full[polarity];
  assign w_in_we  = cwsi & cwri & (cwdi[VC_BIT] == polarity);
  assign w_inj_we = pesi & peri & (pedi[VC_BIT] == polarity);

  assign cwso = w_out_full[polarity] & cwro;
  assign cwdo = cwso ? w_out_data[polarity] : '0;
  assign peso = w_ej_full[polarity] & pero;
  assign pedo = peso ? w_ej_data[polarity] : '0;

  assign w_in_pkt  = w_in_data[w_rv];
  assign w_inj_pkt = w_inj_data[w_rv];
  assign w_in_fwd  = w_in_pkt[HOP_LSB];
  assign w_inj_fwd = w_inj_pkt[HOP_LSB];

  always_comb begin
    w_in_shift  = w_in_pkt;
    w_inj_shift = w_inj_pkt;
    w_in_shift[HOP_MSB:HOP_LSB]  = {1'b0, w_in_pkt[HOP_MSB:HOP_LSB-1]};
    w_inj_shift[HOP_MSB:HOP_LSB] = {1'b0, w_inj_pkt[HOP_MSB:HOP_LSB-1]};
  end

  assign w_in_ok  = w_in_full[w_rv]  & (w_in_fwd  ? ~w_out_full[w_rv] : ~w_ej_full[w_rv]);
  assign w_inj_ok = w_inj_full[w_rv] & (w_inj_fwd ? ~w_out_full[w_rv] : ~w_ej_full[w_rv]);
  assign w_conflict = w_in_ok & w_inj_ok & (w_in_fwd == w_inj_fwd);

  // Only a shared-destination conflict consults and advances the priority bit.
  always_comb begin
    w_in_go  = w_in_ok;
    w_inj_go = w_inj_ok;
    w_toggle = 1'b0;
    if (w_conflict) begin
      w_toggle = 1'b1;
      w_in_go  = (r_prio[w_rv] == SRC_IN);
      w_inj_go = (r_prio[w_rv] == SRC_INJ);
    end
  end

  assign w_out_we    = (w_in_go & w_in_fwd) | (w_inj_go & w_inj_fwd);
  assign w_out_wdata = (w_in_go & w_in_fwd) ? w_in_shift : w_inj_shift;
  assign w_ej_we     = (w_in_go & ~w_in_fwd) | (w_inj_go & ~w_inj_fwd);
  assign w_ej_wdata  = (w_in_go & ~w_in_fwd) ? w_in_pkt : w_inj_pkt;

  assign w_in_clr  = {w_in_go  &  w_rv, w_in_go  & ~w_rv};
  assign w_inj_clr = {w_inj_go &  w_rv, w_inj_go & ~w_rv};
  assign w_out_clr = {cwso & polarity, cwso & ~polarity};
  assign w_ej_clr  = {peso & polarity, peso & ~polarity};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio[0] <= SRC_IN;
      r_prio[1] <= SRC_IN;
    end else if (w_toggle) begin
      r_prio[w_rv] <= (r_prio[w_rv] == SRC_IN) ? SRC_INJ : SRC_IN;
    end
  end

  cardinal_vc_buf #(.WIDTH(PACKET_SIZE)) u_in (
    .clk(clk), .reset(reset), .i_we(w_in_we), .i_vc(polarity), .i_data(cwdi),
    .i_clr(w_in_clr), .o_full(w_in_full), .o_data(w_in_data)
  );

  cardinal_vc_buf #(.WIDTH(PACKET_SIZE)) u_inj (
    .clk(clk), .reset(reset), .i_we(w_inj_we), .i_vc(polarity), .i_data(pedi),
    .i_clr(w_inj_clr), .o_full(w_inj_full), .o_data(w_inj_data)
  );

  cardinal_vc_buf #(.WIDTH(PACKET_SIZE)) u_out (
    .clk(clk), .reset(reset), .i_we(w_out_we), .i_vc(w_rv), .i_data(w_out_wdata),
    .i_clr(w_out_clr), .o_full(w_out_full), .o_data(w_out_data)
  );

  cardinal_vc_buf #(.WIDTH(PACKET_SIZE)) u_ej (
    .clk(clk), .reset(reset), .i_we(w_ej_we), .i_vc(w_rv), .i_data(w_ej_wdata),
    .i_clr(w_ej_clr), .o_full(w_ej_full), .o_data(w_ej_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_cardinal_ring_hop.sv
// +----------------------------------------------------------------------+
// | tb_cardinal_ring_hop : directed and randomized bench for the hop     |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cardinal_ring_hop;

  localparam int P = 64;
  typedef logic [0:P-1] pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic polarity = 1'b0;
  logic cwsi = 1'b0, cwro = 1'b0, pesi = 1'b0, pero = 1'b0;
  pkt_t cwdi = '0, pedi = '0;
  logic cwri, cwso, peri, peso;
  pkt_t cwdo, pedo;

  int total = 0;
  int bad = 0;

  pkt_t obs_fwd[$];
  pkt_t obs_ej[$];

  cardinal_ring_hop #(.PACKET_SIZE(P)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi), .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
    .pesi(pesi), .peri(peri), .pedi(pedi), .peso(peso), .pero(pero), .pedo(pedo)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) polarity <= 1'b0;
    else        polarity <= ~polarity;

  // Every transfer on either output link is recorded mid-cycle.
  always @(negedge clk)
    if (reset) begin
      if (cwso) obs_fwd.push_back(cwdo);
      if (peso) obs_ej.push_back(pedo);
    end

  function automatic pkt_t mk(bit vc, logic [7:0] hop, logic [15:0] src, logic [31:0] pay);
    pkt_t p;
    p = '0;
    p[0] = vc;
    p[8:15] = hop;
    p[16:31] = src;
    p[32:63] = pay;
    return p;
  endfunction

  // One forwarding hop halves the hop count.
  function automatic pkt_t fwd(pkt_t p);
    pkt_t q;
    logic [7:0] h;
    q = p;
    h = p[8:15];
    q[8:15] = h >> 1;
    return q;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_pol(bit p);
    tick();
    if (polarity !== p) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p1, p2, p3, p4, a, b, first, second;
    pkt_t exp_s [2][$];
    pkt_t got_s [2][$];
    pkt_t exp_fwd[$];
    pkt_t exp_ej[$];
    bit   inj_first;
    int   n, guard, idx;
    logic [15:0] seq;

    // Reset held with requests pending
    reset = 1'b0; cwsi = 1'b1; pesi = 1'b1; cwro = 1'b1; pero = 1'b1;
    cwdi = mk(1'b0, 8'h03, 16'h0001, 32'd5);
    pedi = mk(1'b0, 8'h03, 16'h0002, 32'd6);
    repeat (3) tick();
    #3;
    check("rst_cwri", cwri, 0);
    check("rst_peri", peri, 0);
    check("rst_cwso", cwso, 0);
    check("rst_peso", peso, 0);
    check("rst_cwdo", cwdo, 0);
    check("rst_pedo", pedo, 0);
    tick();
    reset = 1'b1; cwsi = 1'b0; pesi = 1'b0;
    #3;
    check("rel_cwri", cwri, 1);
    check("rel_peri", peri, 1);

    // Forward: hop 3 -> 1, two cycles after accept
    go_pol(1'b0);
    p1 = mk(1'b0, 8'h03, 16'h0011, 32'd5);
    cwsi = 1'b1; cwdi = p1;
    tick();
    cwsi = 1'b0;
    #3; check("fwd_early", cwso, 0);
    tick();
    #3; check("fwd_cwso", cwso, 1);
    check("fwd_cwdo", cwdo, fwd(p1));
    check("fwd_hop", cwdo[8:15], 8'h01);
    tick();
    #3; check("fwd_drained", cwso, 0);
    check("fwd_cwdo_zero", cwdo, 0);

    // Eject with hop 2, then backpressure from the NIC
    go_pol(1'b0);
    p2 = mk(1'b0, 8'h02, 16'h0022, 32'd7);
    cwsi = 1'b1; cwdi = p2;
    tick();
    cwsi = 1'b0;
    #3; check("ej_early", peso, 0);
    tick();
    #3; check("ej_peso", peso, 1);
    check("ej_pedo", pedo, p2);
    go_pol(1'b0);
    p3 = mk(1'b0, 8'h02, 16'h0033, 32'd8);
    pero = 1'b0; cwsi = 1'b1; cwdi = p3;
    tick();
    cwsi = 1'b0;
    repeat (6) begin
      #3; check("hold_peso", peso, 0);
      check("hold_cwri", cwri, 1);
      tick();
    end
    go_pol(1'b0);
    p4 = mk(1'b0, 8'h02, 16'h0044, 32'd9);
    cwsi = 1'b1; cwdi = p4;
    tick();
    cwsi = 1'b0;
    #3; check("blk_peso", peso, 0);
    tick();
    #3; check("blk_cwri", cwri, 0);
    check("blk_peso2", peso, 0);
    pero = 1'b1;
    #1; check("rel_peso", peso, 1);
    check("rel_pedo", pedo, p3);
    tick();
    #3; check("rel_gap", peso, 0);
    tick();
    #3; check("rel_peso2", peso, 1);
    check("rel_pedo2", pedo, p4);
    check("rel_cwri2", cwri, 1);

    // Round-robin between IN and INJ on VC 1
    inj_first = 1'b0;
    for (int r = 0; r < 2; r++) begin
      go_pol(1'b1);
      a = mk(1'b1, 8'h01, 16'h0050 + 16'(r), 32'h000A_0000 + 32'(r));
      b = mk(1'b1, 8'h01, 16'h0060 + 16'(r), 32'h000B_0000 + 32'(r));
      cwsi = 1'b1; cwdi = a; pesi = 1'b1; pedi = b;
      tick();
      cwsi = 1'b0; pesi = 1'b0;
      first  = inj_first ? b : a;
      second = inj_first ? a : b;
      inj_first = ~inj_first;
      #3; check("arb_early", cwso, 0);
      tick();
      #3; check("arb_first_v", cwso, 1);
      check("arb_first", cwdo, fwd(first));
      tick();
      #3; check("arb_gap", cwso, 0);
      tick();
      #3; check("arb_second_v", cwso, 1);
      check("arb_second", cwdo, fwd(second));
    end

    // Wrong VC: dropped on both inputs
    go_pol(1'b0);
    cwsi = 1'b1; cwdi = mk(1'b1, 8'h01, 16'h0070, 32'd1);
    pesi = 1'b1; pedi = mk(1'b1, 8'h02, 16'h0071, 32'd2);
    tick();
    cwsi = 1'b0; pesi = 1'b0;
    repeat (6) begin
      #3; check("wvc_cwso", cwso, 0);
      check("wvc_peso", peso, 0);
      tick();
    end

    // Stream of 15 injected packets on alternating VCs
    obs_fwd.delete(); obs_ej.delete();
    n = 0; guard = 0;
    while (n < 15 && guard < 100) begin
      pesi = 1'b1;
      pedi = mk(polarity, 8'h01, 16'(n), 32'(n));
      #2;
      if (peri) begin
        exp_s[polarity].push_back(fwd(pedi));
        n++;
      end
      tick();
      guard++;
    end
    pesi = 1'b0;
    check("stream_accepted", n, 15);
    repeat (8) tick();
    check("stream_count", obs_fwd.size(), 15);
    foreach (obs_fwd[k]) got_s[obs_fwd[k][0]].push_back(obs_fwd[k]);
    for (int v = 0; v < 2; v++) begin
      check("stream_vc_count", got_s[v].size(), exp_s[v].size());
      for (int k = 0; k < exp_s[v].size() && k < got_s[v].size(); k++)
        check("stream_order", got_s[v][k], exp_s[v][k]);
    end

    // Randomized traffic with random link backpressure
    obs_fwd.delete(); obs_ej.delete();
    seq = 16'h1000;
    for (int c = 0; c < 80; c++) begin
      cwsi = 1'($urandom);
      cwdi = mk(1'($urandom), 8'($urandom), seq, $urandom);
      pesi = 1'($urandom);
      pedi = mk(1'($urandom), 8'($urandom), seq + 16'h0800, $urandom);
      seq++;
      cwro = 1'($urandom);
      pero = 1'($urandom);
      #2;
      if (cwsi && cwri && cwdi[0] == polarity) begin
        if (cwdi[15]) exp_fwd.push_back(fwd(cwdi));
        else          exp_ej.push_back(cwdi);
      end
      if (pesi && peri && pedi[0] == polarity) begin
        if (pedi[15]) exp_fwd.push_back(fwd(pedi));
        else          exp_ej.push_back(pedi);
      end
      tick();
    end
    cwsi = 1'b0; pesi = 1'b0; cwro = 1'b1; pero = 1'b1;
    repeat (12) tick();
    foreach (obs_fwd[k]) begin
      idx = -1;
      for (int j = 0; j < exp_fwd.size(); j++)
        if (exp_fwd[j] === obs_fwd[k]) begin idx = j; break; end
      check("rnd_fwd_known", idx >= 0, 1);
      if (idx >= 0) exp_fwd.delete(idx);
    end
    foreach (obs_ej[k]) begin
      idx = -1;
      for (int j = 0; j < exp_ej.size(); j++)
        if (exp_ej[j] === obs_ej[k]) begin idx = j; break; end
      check("rnd_ej_known", idx >= 0, 1);
      if (idx >= 0) exp_ej.delete(idx);
    end
    check("rnd_fwd_missing", exp_fwd.size(), 0);
    check("rnd_ej_missing", exp_ej.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
